zprize_mul_const_csd_seq: RTL and testbench
===========================================

// Module: zprize_mul_const_csd_seq
// PURPOSE
// Iterative, area-reduced constant multiplier: out0 = in0 * CONST[sel], with the constant recoded to
// signed-digit (NAF) terms at elaboration and TPC shifted terms accumulated per cycle. It runs
// with valid/ready handshakes and a metadata sideband. It serves the non-throughput-critical
// reduction and setup paths of the MSM datapath, where a fully unrolled shift-add tree costs too much area.
// PARAMETERS
// W         384      operand width of in0
// CW        384      constant width
// NUM_CONST 2        number of selectable constants (>=1)
// CONST0    384'h0   constant for sel=0 (nonnegative, < 2^CW)
// CONST1    384'h0   constant for sel=1 (used only when NUM_CONST>=2)
// TPC       6        signed terms added per RUN cycle (1..16)
// OUT_MODE  0        0: full product, OW=W+CW; 1: low half, OW=W, product mod 2^W; 2: high part, OW=CW, product>>W
// M         32       metadata width
// PORTS
// clk        in   1         clock
// rst        in   1         asynchronous active-high reset
// in_valid   in   1         input transaction valid
// in_ready   out  1         block can accept (IDLE only)
// in0        in   W         multiplicand
// sel        in   SW        constant select, SW=max(1,$clog2(NUM_CONST))
// m_i        in   M         metadata, returned unchanged with the result
// out_valid  out  1         result valid
// out_ready  in   1         downstream accepts result
// out0       out  OW        product per OUT_MODE
// m_o        out  M         metadata of the transaction in out0
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out0=0, m_o=0, acc=0, cnt=0.
// - Elaboration: each CONSTk is NAF-recoded into Nk terms (shift s_i, sign +/-1), in ascending s_i.
//   Term tables are constant ROMs, with no runtime load path.
// - FSM IDLE->RUN->DONE->IDLE:
//   IDLE: in_ready=1. On in_valid: latch in0, sel, m_i; clear acc and cnt; go to RUN.
//   RUN: in_ready=0. Each cycle: acc += sum of sign_i*(in0<<s_i) for i in [cnt, cnt+TPC); indices >= N[sel] add 0.
//        cnt += TPC. The cycle in which cnt+TPC >= N[sel] is the last RUN cycle; the next state is DONE.
//   DONE: out_valid=1. out0 and m_o are registered and stable until out_ready=1. On out_ready, go to IDLE.
//   No new input is accepted in DONE, and out_valid drops in the cycle after the handshake.
// - Number of RUN cycles: R=max(1,ceil(N[sel]/TPC)). out_valid rises R+1 cycles after the accept cycle.
//   Throughput is one result per R+2 cycles with out_ready held high.
// - Accumulator: signed, W+CW+2 bits. Intermediate values may be negative. The final value equals
//   in0*CONST[sel] exactly, is >=0, and must not wrap.
// - CONST[sel]==0 (N=0) or sel>=NUM_CONST: the operation runs one RUN cycle and returns out0=0
//   with m_o=m_i.
// - OUT_MODE slicing is applied when the result is registered into out0; bits above OW are discarded.
// - in_valid while in_ready=0 is ignored; upstream must hold it. in0, sel and m_i are sampled only
//   on the accept cycle.
// - Reset asserted mid-RUN or mid-DONE aborts the transaction: no output and no partial result
//   are emitted.
// - The datapath adds TPC shifted operands per cycle. If timing needs it, implement this as a
//   balanced adder tree inside one stage. Any extra pipelining must keep the latency R+1 contract
//   by counting extra stages into R.
// TESTING
// 1 W=CW=384, TPC=6, CONST0=p (BLS12-377 base modulus), in0=1, sel=0 -> out0=p (OUT_MODE 0); m_o=m_i=32'hDEADBEEF.
// 2 in0=2^384-1, sel=0 -> out0=(2^384-1)*p exactly; compare against a bignum reference for 1000 random in0.
// 3 CONST1=3 (NAF 4-1, N=2), sel=1, in0=5 -> R=1, out0=15, out_valid exactly 2 cycles after accept.
// 4 sel=1, CONST1=0 -> out0=0 after 2 cycles. With NUM_CONST=2 and a 1-bit sel, also check
//   NUM_CONST=1 with sel=1 -> out0=0.
// 5 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out0/m_o unchanged,
//   in_ready stays 0. Then out_ready=1 -> state IDLE next cycle, in_ready=1.
// 6 Assert rst during the 3rd RUN cycle -> out_valid, out0 and m_o go to 0 immediately. A new
//   transaction (in0=7, sel=0) then gives out0=7*p.
// 7 OUT_MODE=1 and 2 with in0=2^384-1 -> out0 equals the low 384 bits and the upper 384 bits of
//   the full product, respectively.

Source files
------------

// File: rtl/zprize_mul_const_csd_seq.sv
// Iterative constant multiplier: out0 = in0 * CONST[sel] using elaboration-time NAF term ROMs,
// accumulating TPC signed shifted copies of in0 per RUN cycle behind valid/ready handshakes.
module zprize_mul_const_csd_seq #(
    parameter int            W         = 384,
    parameter int            CW        = 384,
    parameter int            NUM_CONST = 2,
    parameter logic [CW-1:0] CONST0    = '0,
    parameter logic [CW-1:0] CONST1    = '0,
    parameter int            TPC       = 6,
    parameter int            OUT_MODE  = 0,
    parameter int            M         = 32,
    localparam int           SW        = (NUM_CONST > 1) ? $clog2(NUM_CONST) : 1,
    localparam int           OW        = (OUT_MODE == 1) ? W : (OUT_MODE == 2) ? CW : W + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in0,
    input  logic [SW-1:0] sel,
    input  logic [M-1:0]  m_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out0,
    output logic [M-1:0]  m_o
);

    localparam int AW   = W + CW + 2;
    localparam int PW   = W + CW;
    localparam int SHW  = (CW > 0) ? $clog2(CW + 1) : 1;
    localparam int TIW  = SHW;
    localparam int CNTW = $clog2(CW + TPC + 2);

    typedef logic [CW:0][SHW-1:0] shtab_t;

    // NAF digits of c: digit i is bit i+1 of 3c minus bit i+1 of c.
    function automatic logic [CW:0] naf_mask(input logic [CW-1:0] c, input logic neg);
        logic [CW+1:0] x;
        logic [CW+1:0] x3;
        logic [CW+1:0] m;
        x  = {2'b00, c};
        x3 = x + (x << 1);
        m  = neg ? (~x3 & x) : (x3 & ~x);
        return m[CW+1:1];
    endfunction

    function automatic int popcnt(input logic [CW:0] v);
        int n;
        n = 0;
        for (int i = 0; i <= CW; i++) n += int'(v[i]);
        return n;
    endfunction

    // Compact the nonzero digit positions into a term list in ascending shift order.
    function automatic shtab_t pack_shift(input logic [CW:0] nz);
        shtab_t t;
        int     k;
        t = '0;
        k = 0;
        for (int i = 0; i <= CW; i++) begin
            if (nz[i]) begin
                t[k] = SHW'(i);
                k++;
            end
        end
        return t;
    endfunction

    function automatic logic [CW:0] pack_neg(input logic [CW:0] nz, input logic [CW:0] ng);
        logic [CW:0] t;
        int          k;
        t = '0;
        k = 0;
        for (int i = 0; i <= CW; i++) begin
            if (nz[i]) begin
                t[k] = ng[i];
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [CW:0] NEGM0 = naf_mask(CONST0, 1'b1);
    localparam logic [CW:0] NZ0   = naf_mask(CONST0, 1'b0) | NEGM0;
    localparam int          N0    = popcnt(NZ0);
    localparam shtab_t      SH0   = pack_shift(NZ0);
    localparam logic [CW:0] NG0   = pack_neg(NZ0, NEGM0);

    localparam logic [CW:0] NEGM1 = naf_mask(CONST1, 1'b1);
    localparam logic [CW:0] NZ1   = naf_mask(CONST1, 1'b0) | NEGM1;
    localparam int          N1    = (NUM_CONST >= 2) ? popcnt(NZ1) : 0;
    localparam shtab_t      SH1   = pack_shift(NZ1);
    localparam logic [CW:0] NG1   = pack_neg(NZ1, NEGM1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_d;
    logic [W-1:0]          in0_q;
    logic                  use1_q;
    logic [CNTW-1:0]       n_q, n_sel;
    logic [CNTW-1:0]       cnt, cnt_nxt;
    logic [M-1:0]          m_q;
    logic signed [AW-1:0]  acc, acc_nxt, sum, ext, term;
    logic [CNTW-1:0]       idx;
    logic [SHW-1:0]        sh;
    logic                  ng;
    logic                  last;
    logic [PW-1:0]         prod;
    logic [OW-1:0]         res;

    always_comb begin
        n_sel = '0;
        if (sel == '0)
            n_sel = CNTW'(N0);
        else if (NUM_CONST >= 2 && sel == SW'(1))
            n_sel = CNTW'(N1);
    end

    assign ext = $signed({{(AW - W){1'b0}}, in0_q});

    // TPC terms per cycle; indices past the term count contribute nothing.
    always_comb begin
        sum  = '0;
        idx  = '0;
        sh   = '0;
        ng   = 1'b0;
        term = '0;
        for (int j = 0; j < TPC; j++) begin
            idx  = cnt + CNTW'(j);
            sh   = use1_q ? SH1[idx[TIW-1:0]] : SH0[idx[TIW-1:0]];
            ng   = use1_q ? NG1[idx[TIW-1:0]] : NG0[idx[TIW-1:0]];
            term = ext <<< sh;
            if (idx < n_q)
                sum = ng ? sum - term : sum + term;
        end
    end

    assign acc_nxt = acc + sum;
    assign cnt_nxt = cnt + CNTW'(TPC);
    assign last    = (cnt_nxt >= n_q);
    assign prod    = acc_nxt[PW-1:0];

    generate
        if (OUT_MODE == 1) begin : g_low
            logic unused_hi;
            assign res       = prod[W-1:0];
            assign unused_hi = ^prod[PW-1:W];
        end else if (OUT_MODE == 2) begin : g_high
            logic unused_lo;
            assign res       = prod[PW-1:W];
            assign unused_lo = ^prod[W-1:0];
        end else begin : g_full
            assign res = prod;
        end
    endgenerate

    logic unused_acc;
    assign unused_acc = ^acc_nxt[AW-1:PW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN:  if (last) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in0_q  <= '0;
            use1_q <= 1'b0;
            n_q    <= '0;
            m_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            out0   <= '0;
            m_o    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in0_q  <= in0;
                    use1_q <= (sel != '0);
                    n_q    <= n_sel;
                    m_q    <= m_i;
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    if (last) begin
                        out0 <= res;
                        m_o  <= m_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zprize_mul_const_csd_seq.sv
// Directed bench for zprize_mul_const_csd_seq: four instances (full/low/high output, and a
// single-constant build) share one stimulus stream and run in lockstep.
module tb_zprize_mul_const_csd_seq;

    localparam logic [383:0] P = 384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001;
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, sel;
    logic [383:0] in0;
    logic [31:0]  m_i;
    logic [3:0]   ir, ov;
    logic [31:0]  mo [4];
    logic [767:0] o0, o3;
    logic [383:0] o1, o2;
    logic [767:0] obs [4];
    int           tests_run = 0, tests_failed = 0;

    always #5 clk = ~clk;

    assign obs[0] = o0;
    assign obs[1] = {384'b0, o1};
    assign obs[2] = {384'b0, o2};
    assign obs[3] = o3;

    zprize_mul_const_csd_seq #(.W(384), .CW(384), .NUM_CONST(2), .CONST0(P), .CONST1(384'd3),
        .TPC(6), .OUT_MODE(0), .M(32)) dut0 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(ir[0]), .in0(in0), .sel(sel), .m_i(m_i), .out_valid(ov[0]),
        .out_ready(out_ready), .out0(o0), .m_o(mo[0]));
    zprize_mul_const_csd_seq #(.W(384), .CW(384), .NUM_CONST(2), .CONST0(P), .CONST1(384'd0),
        .TPC(6), .OUT_MODE(1), .M(32)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(ir[1]), .in0(in0), .sel(sel), .m_i(m_i), .out_valid(ov[1]),
        .out_ready(out_ready), .out0(o1), .m_o(mo[1]));
    zprize_mul_const_csd_seq #(.W(384), .CW(384), .NUM_CONST(2), .CONST0(P), .CONST1(384'd3),
        .TPC(6), .OUT_MODE(2), .M(32)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(ir[2]), .in0(in0), .sel(sel), .m_i(m_i), .out_valid(ov[2]),
        .out_ready(out_ready), .out0(o2), .m_o(mo[2]));
    zprize_mul_const_csd_seq #(.W(384), .CW(384), .NUM_CONST(1), .CONST0(P), .CONST1(384'd3),
        .TPC(6), .OUT_MODE(0), .M(32)) dut3 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(ir[3]), .in0(in0), .sel(sel), .m_i(m_i), .out_valid(ov[3]),
        .out_ready(out_ready), .out0(o3), .m_o(mo[3]));

    // Reference product for instance k; dut1 has CONST1=0 and dut3 has no second constant.
    function automatic logic [767:0] exp_out(input int k, input logic [383:0] a, input logic s);
        logic [383:0] c;
        logic [767:0] f;
        c = (s == 1'b0) ? P : (k == 0 || k == 2) ? 384'd3 : 384'd0;
        f = {384'b0, a} * {384'b0, c};
        case (k)
            1:       return {384'b0, f[383:0]};
            2:       return {384'b0, f[767:384]};
            default: return f;
        endcase
    endfunction

    // Drive one transaction; lat = edges from the accept edge until out_valid, -1 on timeout.
    task automatic run_txn(input logic [383:0] a, input logic s, input logic [31:0] m, output int lat);
        int w;
        w = 0;
        while (!ir[0] && w < LIMIT) begin
            @(posedge clk); #1;
            w++;
        end
        in0 = a; sel = s; m_i = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in0 = ~a; m_i = ~m; sel = ~s;
        lat = 0;
        while (!ov[0] && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov[0]) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in0 = '0; sel = 1'b0; m_i = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || obs[k] !== '0 || mo[k] !== '0) begin
                tests_failed++;
                $display("FAIL reset dut%0d: in_ready=%b out_valid=%b out0=%h m_o=%h want 1 0 0 0",
                         k, ir[k], ov[k], obs[k], mo[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_const_p;
        int lat;
        run_txn(384'd1, 1'b0, 32'hDEADBEEF, lat);
        tests_run++;
        if (lat < 0) begin
            tests_failed++;
            $display("FAIL const_p_timeout: out_valid never rose within %0d cycles", LIMIT);
        end
        tests_run++;
        if (o0 !== {384'b0, P} || mo[0] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL const_p: out0=%h m_o=%h want %h deadbeef", o0, mo[0], P);
        end
        for (int k = 1; k < 4; k++) begin
            tests_run++;
            if (obs[k] !== exp_out(k, 384'd1, 1'b0) || mo[k] !== 32'hDEADBEEF) begin
                tests_failed++;
                $display("FAIL const_p dut%0d: out0=%h want %h", k, obs[k], exp_out(k, 384'd1, 1'b0));
            end
        end
    endtask

    task automatic test_small_const;
        int lat;
        run_txn(384'd5, 1'b1, 32'h00000033, lat);
        tests_run++;
        if (lat !== 1 || ov !== 4'b1111) begin
            tests_failed++;
            $display("FAIL small_latency: edges after accept=%0d out_valid=%b want 1 1111", lat, ov);
        end
        tests_run++;
        if (o0 !== 768'd15 || o1 !== '0 || o2 !== '0 || o3 !== '0 || mo[0] !== 32'h33) begin
            tests_failed++;
            $display("FAIL small_const: out0=%0d/%0d/%0d/%0d m_o=%h want 15/0/0/0 33", o0, o1, o2, o3, mo[0]);
        end
    endtask

    task automatic test_zero_const;
        int lat;
        run_txn(384'd12345, 1'b1, 32'h0000AB00, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL zero_latency: edges after accept=%0d want 1", lat);
        end
        tests_run++;
        if (o1 !== '0 || o3 !== '0 || o0 !== 768'd37035 || mo[1] !== 32'hAB00 || mo[3] !== 32'hAB00) begin
            tests_failed++;
            $display("FAIL zero_const: dut1=%h dut3=%h dut0=%0d m_o=%h want 0 0 37035 ab00", o1, o3, o0, mo[3]);
        end
    endtask

    task automatic test_out_modes;
        int           lat;
        logic [383:0] ones;
        ones = '1;
        run_txn(ones, 1'b0, 32'h00000077, lat);
        // (2^384-1)*p = p*2^384 - p: low half is 2^384-p, high half is p-1.
        tests_run++;
        if (o1 !== (~P + 384'd1) || o2 !== (P - 384'd1)) begin
            tests_failed++;
            $display("FAIL out_modes: low=%h high=%h want %h %h", o1, o2, ~P + 384'd1, P - 384'd1);
        end
        tests_run++;
        if (o0 !== {P - 384'd1, ~P + 384'd1} || lat < 0) begin
            tests_failed++;
            $display("FAIL full_ones: out0=%h want %h", o0, {P - 384'd1, ~P + 384'd1});
        end
    endtask

    task automatic test_random;
        int           lat;
        logic [383:0] a;
        logic [31:0]  m;
        for (int t = 0; t < 1000; t++) begin
            for (int w = 0; w < 12; w++) a[w*32 +: 32] = $urandom();
            m = $urandom();
            run_txn(a, 1'b0, m, lat);
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (lat < 0 || obs[k] !== exp_out(k, a, 1'b0) || mo[k] !== m) begin
                    tests_failed++;
                    $display("FAIL random%0d dut%0d: out0=%h want %h", t, k, obs[k], exp_out(k, a, 1'b0));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int           lat;
        logic [767:0] held;
        out_ready = 1'b0;
        run_txn(384'd11, 1'b0, 32'h00BACC00, lat);
        held = o0;
        tests_run++;
        if (lat < 0 || held !== exp_out(0, 384'd11, 1'b0)) begin
            tests_failed++;
            $display("FAIL bp_result: out0=%h want %h", held, exp_out(0, 384'd11, 1'b0));
        end
        in_valid = 1'b1; in0 = 384'd99;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (ov[0] !== 1'b1 || o0 !== held || mo[0] !== 32'h00BACC00 || ir[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b out0=%h m_o=%h", c, ov[0], ir[0], o0, mo[0]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", ov[0], ir[0]);
        end
    endtask

    task automatic test_back_to_back;
        int acc_cnt, done_cnt;
        acc_cnt = 0; done_cnt = 0;
        in0 = 384'd5; sel = 1'b1; m_i = 32'h1; in_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (ir[0]) acc_cnt++;
            if (ov[0]) done_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (acc_cnt !== 3 || done_cnt !== 3) begin
            tests_failed++;
            $display("FAIL back_to_back: accepts=%0d results=%0d in 9 cycles want 3 3", acc_cnt, done_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun;
        int lat;
        in0 = 384'd9; sel = 1'b0; m_i = 32'h0000C0DE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (ov[k] !== 1'b0 || obs[k] !== '0 || mo[k] !== '0 || ir[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL midrun_reset dut%0d: out_valid=%b out0=%h m_o=%h in_ready=%b",
                         k, ov[k], obs[k], mo[k], ir[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(384'd7, 1'b0, 32'h00000707, lat);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (lat < 0 || obs[k] !== exp_out(k, 384'd7, 1'b0) || mo[k] !== 32'h707) begin
                tests_failed++;
                $display("FAIL after_reset dut%0d: out0=%h want %h", k, obs[k], exp_out(k, 384'd7, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset;
        test_const_p;
        test_small_const;
        test_zero_const;
        test_out_modes;
        test_back_to_back;
        test_backpressure;
        test_reset_midrun;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
